// File: rtl/layer_cfg_pkg.sv
// Shared types and constants for the YOLOv2 layer configuration sequencer.
// ST_ERR only exists when CFG_CHECK_EN is defined.
package layer_cfg_pkg;

  localparam int unsigned CH_W              = 11;
  localparam int unsigned DIM_W             = 9;
  localparam int unsigned SH_W              = 5;
  localparam int unsigned INTER_WIDTH       = 19;
  localparam int unsigned BYTES_PER_ELEM    = 2;
  localparam int unsigned PAD_CH_IN         = 425;
  localparam int unsigned PAD_CH_BIAS       = 428;
  localparam int unsigned OFM_BYTES_SPECIAL = 143656;
  localparam int unsigned CALC_LAT          = 3;
  localparam int unsigned CNT_W             = $clog2(CALC_LAT);

  // Field positions inside the AXI-Lite configuration words
  localparam int unsigned KS_LSB         = 24;
  localparam int unsigned KS_W           = 2;
  localparam int unsigned LTYPE_LSB      = 0;
  localparam int unsigned LTYPE_W        = 8;
  localparam int unsigned HI_LSB         = 16;
  localparam int unsigned LO_LSB         = 0;
  localparam int unsigned EN_RELU_BIT    = 2;
  localparam int unsigned EN_BIAS_BIT    = 1;
  localparam int unsigned EN_MAXPOOL_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_START,
    ST_RUN,
    ST_DONE
`ifdef CFG_CHECK_EN
    , ST_ERR
`endif
  } state_e;

  typedef struct packed {
    logic [KS_W-1:0]    ksize;
    logic [LTYPE_W-1:0] ltype;
    logic               relu;
    logic               bias;
    logic               maxpool;
    logic [CH_W-1:0]    ifm_ch;
    logic [CH_W-1:0]    ofm_ch;
    logic [DIM_W-1:0]   ifm_w;
    logic [DIM_W-1:0]   ifm_h;
    logic [DIM_W-1:0]   ofm_w;
    logic [DIM_W-1:0]   ofm_h;
    logic [SH_W-1:0]    wq;
    logic [SH_W-1:0]    bq;
    logic [SH_W-1:0]    iq;
    logic [SH_W-1:0]    oq;
  } cfg_raw_t;

  typedef struct packed {
    logic             is_relu;
    logic             en_bias;
    logic             maxpooling;
    logic             convolution_3;
    logic             convolution_1;
    logic             is_ofm_shift;
    logic [CH_W-1:0]  ifm_channel;
    logic [CH_W-1:0]  ofm_channel;
    logic [DIM_W-1:0] ifm_width;
    logic [DIM_W-1:0] ifm_height;
    logic [DIM_W-1:0] ofm_width;
    logic [DIM_W-1:0] ofm_height;
    logic [DIM_W-1:0] total_ifm;
    logic [SH_W-1:0]  conv_shift;
    logic [SH_W-1:0]  bias_shift;
    logic [SH_W-1:0]  ofm_shift;
  } cfg_fields_t;

endpackage

// File: rtl/layer_cfg_calc.sv
// Three-stage derived-setting pipeline: fields/flags/shifts, then partial
// products, then DMA byte counts. All stages advance together while en is high.
module layer_cfg_calc
  import layer_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  cfg_raw_t    cfg,
  output cfg_fields_t fields,
  output logic [31:0] bias_bytes,
  output logic [31:0] weight_bytes,
  output logic [31:0] ofm_bytes
);

  cfg_fields_t s1_q, s1_d;
  logic [31:0] k2_q, k2_d, ch_bytes_q, ch_bytes_d;
  logic [31:0] bias_bytes_q, bias_bytes_d, wk_q, wk_d, ofm_area_q, ofm_area_d;
  logic [31:0] weight_bytes_q, weight_bytes_d, ofm_bytes_q, ofm_bytes_d;
  logic        pad_ch;

  assign pad_ch = (s1_q.ofm_channel == CH_W'(PAD_CH_IN));

  always_comb begin
    s1_d           = s1_q;
    k2_d           = k2_q;
    ch_bytes_d     = ch_bytes_q;
    bias_bytes_d   = bias_bytes_q;
    wk_d           = wk_q;
    ofm_area_d     = ofm_area_q;
    weight_bytes_d = weight_bytes_q;
    ofm_bytes_d    = ofm_bytes_q;
    if (en) begin
      s1_d.is_relu       = cfg.relu;
      s1_d.en_bias       = cfg.bias;
      s1_d.maxpooling    = cfg.maxpool;
      s1_d.convolution_3 = !cfg.maxpool && (cfg.ksize == 2'd3);
      s1_d.convolution_1 = !cfg.maxpool && (cfg.ksize == 2'd1);
      s1_d.is_ofm_shift  = (cfg.ltype == '0);
      s1_d.ifm_channel   = cfg.ifm_ch;
      s1_d.ofm_channel   = cfg.ofm_ch;
      s1_d.ifm_width     = cfg.ifm_w;
      s1_d.ifm_height    = cfg.ifm_h;
      s1_d.ofm_width     = cfg.ofm_w;
      s1_d.ofm_height    = cfg.ofm_h;
      s1_d.total_ifm     = s1_d.convolution_3 ? cfg.ifm_w + DIM_W'(2) : cfg.ifm_w;
      // Shifts wrap modulo 2^SH_W by truncation
      s1_d.conv_shift    = SH_W'(32'(cfg.wq) + 32'(cfg.iq) - INTER_WIDTH);
      s1_d.bias_shift    = SH_W'(INTER_WIDTH - 32'(cfg.bq));
      s1_d.ofm_shift     = SH_W'(INTER_WIDTH - 32'(cfg.oq));
      k2_d               = 32'(cfg.ksize) * 32'(cfg.ksize);
      ch_bytes_d         = 32'(cfg.ofm_ch) * BYTES_PER_ELEM;

      bias_bytes_d       = pad_ch ? PAD_CH_BIAS * BYTES_PER_ELEM : ch_bytes_q;
      wk_d               = k2_q * ch_bytes_q;
      ofm_area_d         = 32'(s1_q.ofm_width) * 32'(s1_q.ofm_height);

      weight_bytes_d     = wk_q * 32'(s1_q.ifm_channel);
      ofm_bytes_d        = pad_ch ? OFM_BYTES_SPECIAL : ofm_area_q * ch_bytes_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q           <= '0;
      k2_q           <= '0;
      ch_bytes_q     <= '0;
      bias_bytes_q   <= '0;
      wk_q           <= '0;
      ofm_area_q     <= '0;
      weight_bytes_q <= '0;
      ofm_bytes_q    <= '0;
    end else begin
      s1_q           <= s1_d;
      k2_q           <= k2_d;
      ch_bytes_q     <= ch_bytes_d;
      bias_bytes_q   <= bias_bytes_d;
      wk_q           <= wk_d;
      ofm_area_q     <= ofm_area_d;
      weight_bytes_q <= weight_bytes_d;
      ofm_bytes_q    <= ofm_bytes_d;
    end
  end

  assign fields       = s1_q;
  assign bias_bytes   = bias_bytes_q;
  assign weight_bytes = weight_bytes_q;
  assign ofm_bytes    = ofm_bytes_q;

endmodule

// File: rtl/layer_cfg_sequencer.sv
// Per-layer controller: capture config on ap_start, derive engine settings,
// launch the datapath and report completion. Define CFG_CHECK_EN to reject bad configs.
module layer_cfg_sequencer
  import layer_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      k_s_pad_ltype,
  input  logic [31:0]      iofm_num,
  input  logic [31:0]      ifm_w_h,
  input  logic [31:0]      ofm_w_h,
  input  logic [31:0]      en_bits,
  input  logic [31:0]      weight_q,
  input  logic [31:0]      beta_q,
  input  logic [31:0]      input_q,
  input  logic [31:0]      output_q,
  input  logic             ap_start,
  input  logic             engine_done,
  output logic             ap_idle,
  output logic             ap_done,
  output logic             cfg_valid,
  output logic             hp_start,
  output logic             cfg_err,
  output logic             is_relu,
  output logic             en_bias,
  output logic             maxpooling,
  output logic             convolution_3,
  output logic             convolution_1,
  output logic             is_ofm_shift,
  output logic [CH_W-1:0]  ifm_channel,
  output logic [CH_W-1:0]  ofm_channel,
  output logic [DIM_W-1:0] ifm_width,
  output logic [DIM_W-1:0] ifm_height,
  output logic [DIM_W-1:0] ofm_width,
  output logic [DIM_W-1:0] ofm_height,
  output logic [DIM_W-1:0] total_ifm,
  output logic [SH_W-1:0]  conv_shift,
  output logic [SH_W-1:0]  bias_shift,
  output logic [SH_W-1:0]  ofm_shift,
  output logic [31:0]      bias_bytes,
  output logic [31:0]      weight_bytes,
  output logic [31:0]      ofm_bytes
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cfg_raw_t         shadow_q, shadow_d, cfg_in;
  logic             cfg_valid_q, cfg_valid_d;
  logic             cfg_err_q, cfg_err_d;
  cfg_fields_t      fields;
  logic             unused_bits;

  always_comb begin
    cfg_in         = '0;
    cfg_in.ksize   = k_s_pad_ltype[KS_LSB +: KS_W];
    cfg_in.ltype   = k_s_pad_ltype[LTYPE_LSB +: LTYPE_W];
    cfg_in.relu    = en_bits[EN_RELU_BIT];
    cfg_in.bias    = en_bits[EN_BIAS_BIT];
    cfg_in.maxpool = en_bits[EN_MAXPOOL_BIT];
    cfg_in.ifm_ch  = iofm_num[HI_LSB +: CH_W];
    cfg_in.ofm_ch  = iofm_num[LO_LSB +: CH_W];
    cfg_in.ifm_w   = ifm_w_h[HI_LSB +: DIM_W];
    cfg_in.ifm_h   = ifm_w_h[LO_LSB +: DIM_W];
    cfg_in.ofm_w   = ofm_w_h[HI_LSB +: DIM_W];
    cfg_in.ofm_h   = ofm_w_h[LO_LSB +: DIM_W];
    cfg_in.wq      = weight_q[SH_W-1:0];
    cfg_in.bq      = beta_q[SH_W-1:0];
    cfg_in.iq      = input_q[SH_W-1:0];
    cfg_in.oq      = output_q[SH_W-1:0];
  end

  assign unused_bits = ^{k_s_pad_ltype, iofm_num, ifm_w_h, ofm_w_h, en_bits,
                         weight_q, beta_q, input_q, output_q};

`ifdef CFG_CHECK_EN
  logic reject;
  assign reject = (!shadow_q.maxpool && shadow_q.ksize != 2'd1 && shadow_q.ksize != 2'd3)
               || (shadow_q.ifm_ch == '0) || (shadow_q.ofm_ch == '0)
               || (32'(shadow_q.wq) + 32'(shadow_q.iq) < INTER_WIDTH);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    shadow_d    = shadow_q;
    cfg_valid_d = cfg_valid_q;
    cfg_err_d   = cfg_err_q;
    unique case (state_q)
      ST_IDLE: if (ap_start) begin
        state_d     = ST_CALC;
        shadow_d    = cfg_in;
        cfg_valid_d = 1'b0;
        cfg_err_d   = 1'b0;
      end
      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CALC_LAT - 1)) begin
          cnt_d = '0;
`ifdef CFG_CHECK_EN
          if (reject) begin
            state_d   = ST_ERR;
            cfg_err_d = 1'b1;
          end else
`endif
          begin
            state_d     = ST_START;
            cfg_valid_d = 1'b1;
          end
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN:   if (engine_done) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
`ifdef CFG_CHECK_EN
      ST_ERR:   state_d = ST_DONE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ap_idle  = 1'b0;
    ap_done  = 1'b0;
    hp_start = 1'b0;
    unique case (state_q)
      ST_IDLE:  ap_idle  = 1'b1;
      ST_START: hp_start = 1'b1;
      ST_DONE:  ap_done  = 1'b1;
      default:  ;
    endcase
  end

  assign cfg_valid = cfg_valid_q;
  assign cfg_err   = cfg_err_q;

  layer_cfg_calc u_calc (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (state_q == ST_CALC),
    .cfg          (shadow_q),
    .fields       (fields),
    .bias_bytes   (bias_bytes),
    .weight_bytes (weight_bytes),
    .ofm_bytes    (ofm_bytes)
  );

  assign is_relu       = fields.is_relu;
  assign en_bias       = fields.en_bias;
  assign maxpooling    = fields.maxpooling;
  assign convolution_3 = fields.convolution_3;
  assign convolution_1 = fields.convolution_1;
  assign is_ofm_shift  = fields.is_ofm_shift;
  assign ifm_channel   = fields.ifm_channel;
  assign ofm_channel   = fields.ofm_channel;
  assign ifm_width     = fields.ifm_width;
  assign ifm_height    = fields.ifm_height;
  assign ofm_width     = fields.ofm_width;
  assign ofm_height    = fields.ofm_height;
  assign total_ifm     = fields.total_ifm;
  assign conv_shift    = fields.conv_shift;
  assign bias_shift    = fields.bias_shift;
  assign ofm_shift     = fields.ofm_shift;

endmodule

// File: tb/tb_layer_cfg_sequencer.sv
// Self-checking bench for layer_cfg_sequencer: directed layers, handshake,
// reset abort and randomized layers against an arithmetic reference model.
module tb_layer_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] k_s_pad_ltype, iofm_num, ifm_w_h, ofm_w_h, en_bits;
  logic [31:0] weight_q, beta_q, input_q, output_q;
  logic        ap_start, engine_done;
  logic        ap_idle, ap_done, cfg_valid, hp_start, cfg_err;
  logic        is_relu, en_bias, maxpooling, convolution_3, convolution_1, is_ofm_shift;
  logic [10:0] ifm_channel, ofm_channel;
  logic [8:0]  ifm_width, ifm_height, ofm_width, ofm_height, total_ifm;
  logic [4:0]  conv_shift, bias_shift, ofm_shift;
  logic [31:0] bias_bytes, weight_bytes, ofm_bytes;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int k, ltype, ifm_ch, ofm_ch, ifm_w, ifm_h, ofm_w, ofm_h;
    int relu, bias, mp, wq, bq, iq, oq;
  } layer_t;

  always #5 clk = ~clk;

  layer_cfg_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .k_s_pad_ltype(k_s_pad_ltype), .iofm_num(iofm_num), .ifm_w_h(ifm_w_h),
    .ofm_w_h(ofm_w_h), .en_bits(en_bits), .weight_q(weight_q), .beta_q(beta_q),
    .input_q(input_q), .output_q(output_q), .ap_start(ap_start),
    .engine_done(engine_done), .ap_idle(ap_idle), .ap_done(ap_done),
    .cfg_valid(cfg_valid), .hp_start(hp_start), .cfg_err(cfg_err),
    .is_relu(is_relu), .en_bias(en_bias), .maxpooling(maxpooling),
    .convolution_3(convolution_3), .convolution_1(convolution_1),
    .is_ofm_shift(is_ofm_shift), .ifm_channel(ifm_channel), .ofm_channel(ofm_channel),
    .ifm_width(ifm_width), .ifm_height(ifm_height), .ofm_width(ofm_width),
    .ofm_height(ofm_height), .total_ifm(total_ifm), .conv_shift(conv_shift),
    .bias_shift(bias_shift), .ofm_shift(ofm_shift), .bias_bytes(bias_bytes),
    .weight_bytes(weight_bytes), .ofm_bytes(ofm_bytes)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit rejected(input layer_t c);
`ifdef CFG_CHECK_EN
    return (c.mp == 0 && c.k != 1 && c.k != 3) || c.ifm_ch == 0 || c.ofm_ch == 0
           || (c.wq + c.iq < 19);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int wrap32(input int v);
    return ((v % 32) + 32) % 32;
  endfunction

  task automatic drive(input layer_t c);
    k_s_pad_ltype = {6'($urandom), 2'(c.k), 16'($urandom), 8'(c.ltype)};
    iofm_num      = {5'd0, 11'(c.ifm_ch), 5'd0, 11'(c.ofm_ch)};
    ifm_w_h       = {7'd0, 9'(c.ifm_w), 7'd0, 9'(c.ifm_h)};
    ofm_w_h       = {7'd0, 9'(c.ofm_w), 7'd0, 9'(c.ofm_h)};
    en_bits       = {29'($urandom), 1'(c.relu), 1'(c.bias), 1'(c.mp)};
    weight_q      = {27'($urandom), 5'(c.wq)};
    beta_q        = {27'($urandom), 5'(c.bq)};
    input_q       = {27'($urandom), 5'(c.iq)};
    output_q      = {27'($urandom), 5'(c.oq)};
  endtask

  task automatic check_outputs(input layer_t c, input string n);
    longint chb, expb, expw, expo;
    bit     c3;
    c3   = (c.mp == 0) && (c.k == 3);
    chb  = longint'(c.ofm_ch) * 2;
    expb = (c.ofm_ch == 425) ? 856 : chb;
    expw = (longint'(c.k) * c.k * chb * c.ifm_ch) % (64'd1 << 32);
    expo = (c.ofm_ch == 425) ? 143656 : (longint'(c.ofm_w) * c.ofm_h * chb) % (64'd1 << 32);
    chk({n, ".is_relu"}, is_relu, c.relu);
    chk({n, ".en_bias"}, en_bias, c.bias);
    chk({n, ".maxpooling"}, maxpooling, c.mp);
    chk({n, ".conv3"}, convolution_3, c3);
    chk({n, ".conv1"}, convolution_1, (c.mp == 0) && (c.k == 1));
    chk({n, ".ofm_shift_en"}, is_ofm_shift, c.ltype == 0);
    chk({n, ".ifm_ch"}, ifm_channel, c.ifm_ch);
    chk({n, ".ofm_ch"}, ofm_channel, c.ofm_ch);
    chk({n, ".ifm_w"}, ifm_width, c.ifm_w);
    chk({n, ".ifm_h"}, ifm_height, c.ifm_h);
    chk({n, ".ofm_w"}, ofm_width, c.ofm_w);
    chk({n, ".ofm_h"}, ofm_height, c.ofm_h);
    chk({n, ".total_ifm"}, total_ifm, c3 ? (c.ifm_w + 2) % 512 : c.ifm_w);
    chk({n, ".conv_shift"}, conv_shift, wrap32(c.wq + c.iq - 19));
    chk({n, ".bias_shift"}, bias_shift, wrap32(19 - c.bq));
    chk({n, ".ofm_shift"}, ofm_shift, wrap32(19 - c.oq));
    chk({n, ".bias_bytes"}, bias_bytes, expb);
    chk({n, ".weight_bytes"}, weight_bytes, expw);
    chk({n, ".ofm_bytes"}, ofm_bytes, expo);
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, ".ctl"}, {ap_done, cfg_valid, hp_start, cfg_err, is_relu, en_bias,
                      maxpooling, convolution_3, convolution_1, is_ofm_shift}, 0);
    chk({n, ".dims"}, {ifm_channel, ofm_channel, ifm_width, ifm_height, ofm_width}, 0);
    chk({n, ".dims2"}, {ofm_height, total_ifm, conv_shift, bias_shift, ofm_shift}, 0);
    chk({n, ".bytes"}, {bias_bytes, weight_bytes}, 0);
    chk({n, ".ofm_bytes"}, ofm_bytes, 0);
  endtask

  // Runs one layer from capture to return to idle; ends one cycle into IDLE.
  task automatic run_layer(input layer_t c, input string n, input bit hold, input bit spurious);
    int cyc;
    bit rej;
    rej = rejected(c);
    drive(c);
    ap_start = 1'b1;
    tick();
    if (!hold) ap_start = 1'b0;
    cyc = 1;
    chk({n, ".ap_idle_calc"}, ap_idle, 0);
    chk({n, ".cfg_valid_calc"}, cfg_valid, 0);
    chk({n, ".cfg_err_calc"}, cfg_err, 0);
    if (spurious) begin
      engine_done = 1'b1;
      tick();
      engine_done = 1'b0;
      cyc++;
    end
    while (!(hp_start === 1'b1 || cfg_err === 1'b1) && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({n, ".launch_latency"}, cyc, 4);
    if (rej) begin
      chk({n, ".cfg_err"}, cfg_err, 1);
      chk({n, ".no_hp_start"}, hp_start, 0);
      tick();
      chk({n, ".err_ap_done"}, ap_done, 1);
      chk({n, ".err_no_hp"}, hp_start, 0);
      tick();
      chk({n, ".err_idle"}, ap_idle, 1);
      chk({n, ".cfg_err_sticky"}, cfg_err, 1);
    end else begin
      chk({n, ".hp_start"}, hp_start, 1);
      chk({n, ".cfg_err_ok"}, cfg_err, 0);
      chk({n, ".cfg_valid"}, cfg_valid, 1);
      check_outputs(c, n);
      tick();
      chk({n, ".hp_pulse_len"}, hp_start, 0);
      repeat (8) tick();
      chk({n, ".no_early_done"}, ap_done, 0);
      engine_done = 1'b1;
      tick();
      engine_done = 1'b0;
      chk({n, ".ap_done"}, ap_done, 1);
      tick();
      chk({n, ".done_pulse_len"}, ap_done, 0);
      chk({n, ".idle_after"}, ap_idle, 1);
      chk({n, ".valid_held"}, cfg_valid, 1);
      chk({n, ".bytes_held"}, ofm_bytes,
          (c.ofm_ch == 425) ? 143656 : (longint'(c.ofm_w) * c.ofm_h * c.ofm_ch * 2) % (64'd1 << 32));
    end
  endtask

  initial begin
    layer_t conv3, fin, mpool, badk, r;
    conv3 = '{3, 0, 16, 32, 54, 54, 52, 52, 1, 1, 0, 14, 11, 12, 13};
    fin   = '{1, 1, 1024, 425, 13, 13, 13, 13, 0, 1, 0, 14, 11, 12, 13};
    mpool = '{3, 2, 64, 64, 26, 26, 13, 13, 0, 0, 1, 14, 11, 12, 13};
    badk  = '{2, 0, 16, 32, 54, 54, 52, 52, 1, 1, 0, 14, 11, 12, 13};

    rst_n = 1'b0;
    ap_start = 1'b0;
    engine_done = 1'b0;
    drive(conv3);
    repeat (2) tick();
    chk("reset.ap_idle", ap_idle, 1);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("reset.idle_stays", ap_idle, 1);

    run_layer(conv3, "conv3", 1'b0, 1'b1);
    chk("conv3.conv_shift_lit", conv_shift, 7);
    chk("conv3.weight_lit", weight_bytes, 9216);
    chk("conv3.ofm_bytes_lit", ofm_bytes, 173056);
    run_layer(fin, "final", 1'b0, 1'b0);
    chk("final.bias_lit", bias_bytes, 856);
    chk("final.weight_lit", weight_bytes, 870400);
    run_layer(mpool, "maxpool", 1'b0, 1'b0);
    run_layer(badk, "badk", 1'b0, 1'b0);

    // ap_start held high: the idle cycle after DONE is followed by a new capture
    run_layer(conv3, "hold1", 1'b1, 1'b0);
    chk("hold.ap_idle_gap", ap_idle, 1);
    run_layer(fin, "hold2", 1'b0, 1'b0);

    // Reset while in RUN
    drive(conv3);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    repeat (4) tick();
    chk("rstrun.in_run", {ap_idle, hp_start, ap_done}, 0);
    rst_n = 1'b0;
    tick();
    chk("rstrun.ap_idle", ap_idle, 1);
    chk_all_zero("rstrun");
    rst_n = 1'b1;
    engine_done = 1'b1;
    tick();
    engine_done = 1'b0;
    chk("rstrun.no_done", ap_done, 0);
    tick();
    chk("rstrun.no_done2", ap_done, 0);
    chk("rstrun.idle", ap_idle, 1);

    for (int i = 0; i < 20; i++) begin
      r.k      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : ($urandom_range(0, 1) ? 1 : 3);
      r.ltype  = $urandom_range(0, 3);
      r.ifm_ch = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 2047));
      r.ofm_ch = ($urandom_range(0, 4) == 0) ? 425 : int'($urandom_range(0, 2047));
      r.ifm_w  = $urandom_range(0, 511);
      r.ifm_h  = $urandom_range(0, 511);
      r.ofm_w  = $urandom_range(0, 511);
      r.ofm_h  = $urandom_range(0, 511);
      r.relu   = $urandom_range(0, 1);
      r.bias   = $urandom_range(0, 1);
      r.mp     = $urandom_range(0, 1);
      r.wq     = $urandom_range(0, 31);
      r.bq     = $urandom_range(0, 31);
      r.iq     = $urandom_range(0, 31);
      r.oq     = $urandom_range(0, 31);
      run_layer(r, $sformatf("rand%0d", i), 1'b0, 1'(i % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_cfg_sequencer.md
Name: layer_cfg_sequencer

Overview:
Next-generation layer controller for the YOLOv2 accelerator. It captures the per-layer AXI-Lite configuration words on ap_start. It then computes the derived engine settings (mode flags, dimensions, Q-shifts, DMA transfer byte counts) over a fixed multi-cycle arithmetic pipeline. Finally it launches the HP-port datapath with a one-cycle start pulse and tracks completion with an ap_idle/ap_done handshake. Sits between the PS register file and the conv/maxpool engine plus DMA movers.

Parameters:
CH_W, 11, channel count width (ifm/ofm channels)
DIM_W, 9, feature-map width/height width
SH_W, 5, Q-shift width
INTER_WIDTH, 19, intermediate accumulator Q position
BYTES_PER_ELEM, 2, bytes per activation/weight element
PAD_CH_IN, 425, ofm channel count that triggers padded transfers
PAD_CH_BIAS, 428, padded channel count used for bias transfer
OFM_BYTES_SPECIAL, 143656, fixed ofm byte count when ofm_ch==PAD_CH_IN
CALC_LAT, 3, cycles spent in CALC (multiplier pipeline depth)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
k_s_pad_ltype  in  32  [25:24] kernel size, [7:0] layer type (0 => ofm shift enabled)
iofm_num  in  32  [31:16] ifm channels, [15:0] ofm channels
ifm_w_h  in  32  [31:16] ifm width, [15:0] ifm height
ofm_w_h  in  32  [31:16] ofm width, [15:0] ofm height
en_bits  in  32  [2] relu, [1] bias, [0] maxpool
weight_q, beta_q, input_q, output_q  in  32 each  Q formats; only [SH_W-1:0] used
ap_start  in  1  level start request
engine_done  in  1  one-cycle completion pulse from datapath
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle done pulse
cfg_valid  out  1  derived outputs stable
hp_start  out  1  one-cycle datapath launch pulse
cfg_err  out  1  configuration rejected (sticky until next start)
is_relu, en_bias, maxpooling, convolution_3, convolution_1, is_ofm_shift  out  1 each  mode flags
ifm_channel, ofm_channel  out  CH_W  channels
ifm_width, ifm_height, ofm_width, ofm_height, total_ifm  out  DIM_W  dimensions
conv_shift, bias_shift, ofm_shift  out  SH_W  shifts
bias_bytes, weight_bytes, ofm_bytes  out  32  DMA transfer lengths

Behaviour:
- Reset: state IDLE; ap_idle=1; every other output 0. Reset mid-operation aborts to IDLE in one edge; an engine_done arriving later is ignored.
- States: IDLE -> CALC -> START -> RUN -> DONE -> IDLE; ERR replaces START when check fails (see Optional Feature).
- IDLE: ap_start=1 at an edge captures all config words into shadow registers and enters CALC. cfg_valid drops to 0 and cfg_err clears. Inputs are ignored outside this edge.
- CALC: counter runs CALC_LAT cycles.
  - Stage 1: field extraction, flags, shifts, k2=k*k, ch_bytes=ofm_ch*BYTES_PER_ELEM.
  - Stage 2: bias_bytes = (ofm_ch==PAD_CH_IN) ? PAD_CH_BIAS*BYTES_PER_ELEM : ch_bytes; wk = k2*ch_bytes; ofm_area = ofm_w*ofm_h.
  - Stage 3: weight_bytes = wk*ifm_ch; ofm_bytes = (ofm_ch==PAD_CH_IN) ? OFM_BYTES_SPECIAL : ofm_area*ch_bytes.
  - All products truncate to 32 bits.
- Flag and dimension rules:
  - convolution_3 = !maxpool && k==3; convolution_1 = !maxpool && k==1.
  - total_ifm = ifm_w+2 when convolution_3, else ifm_w.
  - is_ofm_shift = (layer type == 0).
- Shift rules, modulo 2^SH_W:
  - conv_shift = wq+iq-INTER_WIDTH
  - bias_shift = INTER_WIDTH-bq
  - ofm_shift = INTER_WIDTH-oq
- START: hp_start=1 for exactly one cycle; cfg_valid=1 from START until the next accepted ap_start. hp_start is first high 4 cycles after the capture edge (CALC_LAT+1).
- RUN: waits for engine_done. ap_start is ignored.
- DONE: ap_done=1 for one cycle, then IDLE. If ap_start is still high in IDLE, the next capture happens on the following edge.
- engine_done in any state other than RUN is ignored.

Optional Feature:
- Macro CFG_CHECK_EN.
- Defined: in the last CALC cycle, the configuration is rejected if any of these hold: kernel size not in {1,3} with maxpool=0; ifm_ch==0; ofm_ch==0; wq+iq<INTER_WIDTH. On rejection the state goes to ERR instead of START: no hp_start, cfg_err=1, then DONE (ap_done pulse) next cycle.
- Undefined: no check; cfg_err tied 0; ERR state absent.

Decomposition:
- Package layer_cfg_pkg: state enum, bit-field position constants for the config words, INTER_WIDTH/PAD defaults.
- One sub-module: layer_cfg_calc (3-stage arithmetic pipeline, pure datapath with a stage-enable input). The FSM stays in the top.

Test Plan:
- Conv3 layer: k=3, ifm_ch=16, ofm_ch=32, ifm 54x54, ofm 52x52, en_bits=3'b110, wq=14, iq=12, bq=11, oq=13 -> conv_shift=7, bias_shift=8, ofm_shift=6, bias_bytes=64, weight_bytes=9216, ofm_bytes=173056, total_ifm=56, convolution_3=1, hp_start 4 cycles after capture.
- Special final layer: k=1, ifm_ch=1024, ofm_ch=425, ofm 13x13 -> bias_bytes=856, weight_bytes=870400, ofm_bytes=143656, convolution_1=1.
- Maxpool layer: en_bits=3'b001, k=3 -> maxpooling=1, convolution_3=0, total_ifm=ifm_w.
- Handshake: engine_done pulsed 10 cycles after hp_start -> ap_done one cycle later, ap_idle=1 after that. A spurious engine_done during CALC has no effect. ap_start held high -> second hp_start occurs.
- Reset asserted in RUN -> IDLE next edge, all outputs 0, ap_idle=1. A later engine_done produces no ap_done.
- CFG_CHECK_EN: k=2, maxpool=0 -> cfg_err=1, ap_done pulse, no hp_start. Without the macro, the same stimulus gives hp_start with cfg_err=0.
